// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser receive stage.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned PARITY_MAX_W  = 64;

    // Even parity of a word zero-extended to PARITY_MAX_W bits.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_out_fifo.sv
// Two-entry output buffer: registered head word and valid, FIFO order.
module sipo_out_fifo
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full_c,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    logic [1:0]       count_q;
    logic [1:0]       count_next;
    logic [WIDTH-1:0] tail_q;
    logic [WIDTH-1:0] head_next;
    logic [WIDTH-1:0] tail_next;
    logic             pop_ok;

    assign full_c = (count_q == 2'd2);
    assign pop_ok = pop && (count_q != 2'd0);

    // Head keeps its last value when the buffer drains.
    always_comb begin
        count_next = count_q;
        head_next  = out_data;
        tail_next  = tail_q;
        if (pop_ok && push) begin
            if (count_q == 2'd2) begin
                head_next = tail_q;
                tail_next = push_data;
            end else begin
                head_next = push_data;
            end
        end else if (pop_ok) begin
            if (count_q == 2'd2) begin
                head_next = tail_q;
            end
            count_next = count_q - 2'd1;
        end else if (push && !full_c) begin
            if (count_q == 2'd0) begin
                head_next = push_data;
            end else begin
                tail_next = push_data;
            end
            count_next = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            out_data  <= '0;
            tail_q    <= '0;
            out_valid <= 1'b0;
        end else begin
            count_q   <= count_next;
            out_data  <= head_next;
            tail_q    <= tail_next;
            out_valid <= (count_next != 2'd0);
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel receiver with 2-entry output buffer and sticky overrun.
// Optional trailing even-parity bit when PARITY_CHECK_EN is defined.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             busy,
    output logic             parity_err
);

    localparam int unsigned       CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] push_data;
    logic             last_bit;
    logic             pop;
    logic             full_c;
    logic             drop;

    // The bit that completes a frame pushes the word on its own edge.
    always_comb begin
        if (MSB_FIRST) begin
            shift_next = {shift_q[WIDTH-2:0], serial_in};
        end else begin
            shift_next = {serial_in, shift_q[WIDTH-1:1]};
        end
`ifdef PARITY_CHECK_EN
        last_bit  = serial_valid && (state == PARITY);
        push_data = shift_q;
`else
        last_bit  = serial_valid && (state == SHIFT) && (count == LAST_CNT);
        push_data = shift_next;
`endif
    end

    assign pop  = out_valid && out_ready;
    assign drop = last_bit && full_c && !pop;

    // Frame FSM; a completing bit takes priority over sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            shift_q    <= '0;
            busy       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (last_bit) begin
                state <= IDLE;
                count <= '0;
                busy  <= 1'b0;
`ifdef PARITY_CHECK_EN
                parity_err <= even_parity(PARITY_MAX_W'(shift_q)) ^ serial_in;
`else
                shift_q <= shift_next;
`endif
            end else if (serial_valid && (sync || state == IDLE)) begin
                state   <= SHIFT;
                count   <= CNT_W'(1);
                shift_q <= shift_next;
                busy    <= 1'b1;
            end else if (sync) begin
                state <= IDLE;
                count <= '0;
                busy  <= 1'b0;
            end else if (serial_valid && state == SHIFT) begin
                shift_q <= shift_next;
`ifdef PARITY_CHECK_EN
                if (count == LAST_CNT) begin
                    state <= PARITY;
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
`else
                count <= count + 1'b1;
`endif
            end
        end
    end

    // A new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    sipo_out_fifo #(.WIDTH(WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (last_bit),
        .push_data (push_data),
        .pop       (pop),
        .full_c    (full_c),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser (MSB-first and LSB-first instances).
// Parity frames are exercised when PARITY_CHECK_EN is defined.
module tb_sipo_deser;

`ifdef PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       serial_in;
    logic       serial_valid;
    logic       sync;
    logic       out_ready;
    logic       clr_overrun;
    logic [7:0] out_data;
    logic       out_valid;
    logic       overrun;
    logic       busy;
    logic       parity_err;
    logic [7:0] out_data_l;
    logic       out_valid_l;
    logic       overrun_l;
    logic       busy_l;
    logic       parity_err_l;

    int checks = 0;
    int errors = 0;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .serial_valid(serial_valid),
        .sync(sync), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .clr_overrun(clr_overrun), .busy(busy), .parity_err(parity_err)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .serial_valid(serial_valid),
        .sync(sync), .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .overrun(overrun_l), .clr_overrun(clr_overrun), .busy(busy_l), .parity_err(parity_err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bits;     // transmission order, first bit at [7]
        int         gap;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply_last(input logic [3:0] ctl);
        clr_overrun = ctl[2];
        sync        = ctl[1];
        if (ctl[0]) out_ready = 1'b1;
    endtask

    // ctl: [3] sync on first bit, [2] clr_overrun / [1] sync / [0] out_ready on final bit
    task automatic send_frame(input logic [7:0] bits, input int gap, input logic bad_par,
                              input logic [3:0] ctl, input logic chk_busy);
        logic saved_ready;
        saved_ready = out_ready;
        for (int i = 0; i < 8; i++) begin
            serial_in    = bits[7-i];
            serial_valid = 1'b1;
            sync         = (i == 0) && ctl[3];
            if (i == 7 && !PAR) apply_last(ctl);
            tick();
            serial_valid = 1'b0;
            sync         = 1'b0;
            clr_overrun  = 1'b0;
            out_ready    = saved_ready;
            if (chk_busy && (i < 7 || PAR)) chk("busy_mid", busy, 1);
            if (i < 7) repeat (gap) tick();
        end
        if (PAR) begin
            serial_in    = (^bits) ^ bad_par;
            serial_valid = 1'b1;
            apply_last(ctl);
            tick();
            serial_valid = 1'b0;
            sync         = 1'b0;
            clr_overrun  = 1'b0;
            out_ready    = saved_ready;
        end
        if (chk_busy) chk("busy_end", busy, 0);
    endtask

    initial begin
        logic [7:0] w55;
        tbl[0] = '{8'b1011_0011, 0, 8'hB3, 8'hCD};
        tbl[1] = '{8'b1100_1101, 0, 8'hCD, 8'hB3};
        tbl[2] = '{8'h00,        2, 8'h00, 8'h00};
        tbl[3] = '{8'hFF,        0, 8'hFF, 8'hFF};
        tbl[4] = '{8'h80,        1, 8'h80, 8'h01};
        tbl[5] = '{8'h10,        3, 8'h10, 8'h08};
        tbl[6] = '{8'hE2,        0, 8'hE2, 8'h47};

        rst_n = 1'b0; serial_in = 1'b0; serial_valid = 1'b0; sync = 1'b0;
        out_ready = 1'b0; clr_overrun = 1'b0;
        #23;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_parity_err", parity_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table: one word each, consumer always ready, valid lasts one cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            send_frame(tbl[k].bits, tbl[k].gap, 1'b0, 4'b0000, 1'b1);
            chk($sformatf("tbl%0d_valid_msb", k), out_valid, 1);
            chk($sformatf("tbl%0d_data_msb", k), out_data, tbl[k].exp_msb);
            chk($sformatf("tbl%0d_valid_lsb", k), out_valid_l, 1);
            chk($sformatf("tbl%0d_data_lsb", k), out_data_l, tbl[k].exp_lsb);
            tick();
            chk($sformatf("tbl%0d_valid_gone", k), out_valid, 0);
        end

        // Overrun, clear, and set-beats-clear.
        out_ready = 1'b0;
        send_frame(8'hB3, 0, 1'b0, 4'b0000, 1'b1);
        send_frame(8'hAA, 0, 1'b0, 4'b0000, 1'b1);
        chk("ovr_full_no_ovr", overrun, 0);
        chk("ovr_head_b3", out_data, 8'hB3);
        send_frame(8'hFF, 0, 1'b0, 4'b0000, 1'b1);
        chk("ovr_set", overrun, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_clr", overrun, 0);
        send_frame(8'h5A, 0, 1'b0, 4'b0100, 1'b1);
        chk("ovr_set_wins", overrun, 1);
        out_ready = 1'b1;
        chk("drain_b3", out_data, 8'hB3);
        tick();
        chk("drain_aa", out_data, 8'hAA);
        chk("drain_aa_valid", out_valid, 1);
        tick();
        chk("drain_empty", out_valid, 0);
        chk("drain_hold", out_data, 8'hAA);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_clr2", overrun, 0);

        // sync mid-frame with a bit: only the new frame is delivered.
        w55 = 8'h55;
        for (int i = 0; i < 3; i++) begin
            serial_in = w55[7-i]; serial_valid = 1'b1;
            tick();
            serial_valid = 1'b0;
            chk("sync_pre_busy", busy, 1);
        end
        send_frame(8'hE2, 0, 1'b0, 4'b1000, 1'b1);
        chk("sync_valid", out_valid, 1);
        chk("sync_data", out_data, 8'hE2);
        tick();
        chk("sync_one_word", out_valid, 0);

        // sync on the completing edge still pushes the word.
        send_frame(8'h3C, 0, 1'b0, 4'b0010, 1'b1);
        chk("sync_last_data", out_data, 8'h3C);
        tick();
        send_frame(8'h81, 0, 1'b0, 4'b0000, 1'b1);
        chk("sync_last_next", out_data, 8'h81);
        tick();

        // Full buffer: pop and push on the same edge.
        out_ready = 1'b0;
        send_frame(8'h11, 0, 1'b0, 4'b0000, 1'b1);
        send_frame(8'h22, 0, 1'b0, 4'b0000, 1'b1);
        send_frame(8'h33, 0, 1'b0, 4'b0001, 1'b1);
        chk("pp_no_ovr", overrun, 0);
        chk("pp_head_22", out_data, 8'h22);
        chk("pp_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("pp_head_33", out_data, 8'h33);
        chk("pp_valid2", out_valid, 1);
        tick();
        chk("pp_empty", out_valid, 0);

        // Reset mid-frame with two words buffered.
        out_ready = 1'b0;
        send_frame(8'h44, 0, 1'b0, 4'b0000, 1'b0);
        send_frame(8'h55, 0, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            serial_in = i[0]; serial_valid = 1'b1;
            tick();
            serial_valid = 1'b0;
        end
        chk("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_data", out_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send_frame(8'h10, 0, 1'b0, 4'b0000, 1'b1);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 8'h10);
        tick();

`ifdef PARITY_CHECK_EN
        send_frame(8'hB3, 0, 1'b0, 4'b0000, 1'b1);
        chk("par_good_err", parity_err, 0);
        chk("par_good_data", out_data, 8'hB3);
        tick();
        send_frame(8'hB3, 0, 1'b1, 4'b0000, 1'b1);
        chk("par_bad_err", parity_err, 1);
        chk("par_bad_data", out_data, 8'hB3);
        chk("par_bad_valid", out_valid, 1);
        tick();
        chk("par_err_pulse", parity_err, 0);
`else
        send_frame(8'hB3, 0, 1'b0, 4'b0000, 1'b1);
        chk("nopar_err", parity_err, 0);
        chk("nopar_data", out_data, 8'hB3);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
